// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register.
//   MODE_W      width of the per-cycle operation select
//   MODE_*      operation encodings (110/111 are reserved and act as HOLD)
// -----------------------------------------------------------------------------
package usr_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;

endpackage

// File: rtl/usr_shift_counter.sv
// -----------------------------------------------------------------------------
// usr_shift_counter
// Counts serial shifts modulo WIDTH and raises a registered one-cycle
// word_valid pulse on the cycle after the WIDTH-th shift.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset (clears count and pulse)
//   en          clock enable; 0 holds the count and drops the pulse
//   inc         count one shift this cycle
//   clr         restart the word (LOAD); wins over inc
//   cnt         shifts since the last load / word boundary
//   word_valid  one-cycle pulse: a full word has been shifted
// -----------------------------------------------------------------------------
module usr_shift_counter
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             word_valid
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_wv;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_wv_nxt;

   // Next count and pulse; the pulse is only ever high for the wrap cycle.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_wv_nxt  = 1'b0;
      if (!en) begin
         w_cnt_nxt = r_cnt;
      end else if (clr) begin
         w_cnt_nxt = '0;
      end else if (inc) begin
         if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = '0;
            w_wv_nxt  = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
         end
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Count and pulse registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
         r_wv  <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_wv  <= w_wv_nxt;
      end
   end

   assign cnt        = r_cnt;
   assign word_valid = r_wv;

endmodule

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
// WIDTH-bit shift register with per-cycle mode select (hold, shift left,
// shift right, parallel load, optional rotate) and a framed shift counter.
// Optional feature macro: USR_ROTATE_EN (modes 100/101 rotate; otherwise HOLD).
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset; dominates en and mode
//   en          clock enable; 0 holds all state
//   mode        operation select (see usr_pkg)
//   sin_l       serial in at bit 0 on SHL
//   sin_r       serial in at bit WIDTH-1 on SHR
//   par_in      parallel load data
//   q           register contents
//   dout        serial out, q[WIDTH-1]
//   dout_lsb    serial out, q[0]
//   shift_cnt   shifts since last load / word boundary
//   word_valid  one-cycle pulse after WIDTH shifts
// -----------------------------------------------------------------------------
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic              sin_l,
   input  logic              sin_r,
   input  logic [WIDTH-1:0]  par_in,
   output logic [WIDTH-1:0]  q,
   output logic              dout,
   output logic              dout_lsb,
   output logic [CNT_W-1:0]  shift_cnt,
   output logic              word_valid
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_inc;
   logic             w_clr;

   // Data path mux; also tells the counter whether this cycle counts or restarts.
   always_comb begin
      w_q_nxt = r_q;
      w_inc   = 1'b0;
      w_clr   = 1'b0;
      case (mode)
         MODE_HOLD: begin
            w_q_nxt = r_q;
         end
         MODE_SHL: begin
            w_q_nxt = {r_q[WIDTH-2:0], sin_l};
            w_inc   = 1'b1;
         end
         MODE_SHR: begin
            w_q_nxt = {sin_r, r_q[WIDTH-1:1]};
            w_inc   = 1'b1;
         end
         MODE_LOAD: begin
            w_q_nxt = par_in;
            w_clr   = 1'b1;
         end
`ifdef USR_ROTATE_EN
         MODE_ROTL: begin
            w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
         end
         MODE_ROTR: begin
            w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
         end
`endif
         default: begin
            // Reserved codes (and rotates when not built) behave as HOLD.
            w_q_nxt = r_q;
         end
      endcase
   end

   // Register contents; en gates every update except reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= w_q_nxt;
      end else begin
         r_q <= r_q;
      end
   end

   usr_shift_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .inc        (w_inc),
      .clr        (w_clr),
      .cnt        (shift_cnt),
      .word_valid (word_valid)
   );

   assign q        = r_q;
   assign dout     = r_q[WIDTH-1];
   assign dout_lsb = r_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [2:0] mode;
   logic       sin_l;
   logic       sin_r;
   logic [7:0] par_in;
   logic [7:0] q;
   logic       dout;
   logic       dout_lsb;
   logic [2:0] shift_cnt;
   logic       word_valid;

   int total = 0;
   int bad   = 0;

   // Reference model state: plain integers updated from the mode rules.
   int m_q   = 0;
   int m_cnt = 0;
   int m_wv  = 0;

   universal_shift_register #(.WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .sin_l      (sin_l),
      .sin_r      (sin_r),
      .par_in     (par_in),
      .q          (q),
      .dout       (dout),
      .dout_lsb   (dout_lsb),
      .shift_cnt  (shift_cnt),
      .word_valid (word_valid)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, advance the model on the edge, sample 1 time unit later.
   task automatic cyc(input bit r, input bit e, input int md, input bit sl, input bit sr, input int pi);
      bit counts;
      reset  = r;
      en     = e;
      mode   = 3'(md);
      sin_l  = sl;
      sin_r  = sr;
      par_in = 8'(pi);
      @(posedge clk);
      counts = 1'b0;
      if (!r) begin
         m_q = 0; m_cnt = 0; m_wv = 0;
      end else if (!e) begin
         m_wv = 0;
      end else begin
         m_wv = 0;
         case (md)
            1: begin m_q = ((m_q * 2) + sl) % 256; counts = 1'b1; end
            2: begin m_q = (m_q / 2) + (sr ? 128 : 0); counts = 1'b1; end
            3: begin m_q = pi % 256; m_cnt = 0; end
`ifdef USR_ROTATE_EN
            4: m_q = ((m_q * 2) % 256) + (m_q / 128);
            5: m_q = (m_q / 2) + ((m_q % 2) * 128);
`endif
            default: ;
         endcase
         if (counts) begin
            if (m_cnt == 7) m_wv = 1;
            m_cnt = (m_cnt + 1) % 8;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      cyc(0, 1, 3, 1, 1, 8'hFF);
      cyc(0, 0, 1, 1, 1, 8'hFF);
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
      total++; if (shift_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
      total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_wv got=%b exp=0", word_valid); end
      total++; if (dout !== 1'b0 || dout_lsb !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b%b exp=00", dout, dout_lsb); end
   endtask

   task automatic test_siso;
      logic [3:0] pat;
      pat = 4'b1011;
      cyc(1, 1, 3, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         cyc(1, 1, 1, (i < 4) ? pat[3-i] : 1'b0, 0, 0);
         total++;
         if (word_valid !== ((i == 7) ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL siso_wv shift=%0d got=%b exp=%b", i + 1, word_valid, (i == 7));
         end
         if (i >= 7) begin
            total++;
            if (dout !== pat[10-i]) begin bad++; $display("FAIL siso_dout shift=%0d got=%b exp=%b", i + 1, dout, pat[10-i]); end
         end
      end
      total++; if (shift_cnt !== 3'd3) begin bad++; $display("FAIL siso_cnt got=%0d exp=3", shift_cnt); end
   endtask

   task automatic test_load_shr;
      logic [7:0] ld;
      ld = 8'hA5;
      cyc(1, 1, 3, 0, 0, ld);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (dout_lsb !== ld[i]) begin bad++; $display("FAIL shr_lsb bit=%0d got=%b exp=%b", i, dout_lsb, ld[i]); end
         cyc(1, 1, 2, 0, 0, 0);
      end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL shr_q got=%h exp=00", q); end
      total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL shr_wv got=%b exp=1", word_valid); end
   endtask

   task automatic test_rotate;
      logic [7:0] e1, e2;
`ifdef USR_ROTATE_EN
      e1 = 8'h03; e2 = 8'hC0;
`else
      e1 = 8'h81; e2 = 8'h81;
`endif
      cyc(1, 1, 3, 0, 0, 8'h81);
      cyc(1, 1, 4, 1, 1, 0);
      total++; if (q !== e1) begin bad++; $display("FAIL rotl_q got=%h exp=%h", q, e1); end
      cyc(1, 1, 5, 1, 1, 0);
      cyc(1, 1, 5, 1, 1, 0);
      total++; if (q !== e2) begin bad++; $display("FAIL rotr_q got=%h exp=%h", q, e2); end
      total++; if (shift_cnt !== 3'd0 || word_valid !== 1'b0) begin
         bad++; $display("FAIL rot_cnt got=%0d/%b exp=0/0", shift_cnt, word_valid);
      end
   endtask

   task automatic test_edges;
      logic [7:0] held;
      // 16 continuous shifts: pulses after shifts 8 and 16 only.
      cyc(1, 1, 3, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 1, 1, 1'($urandom_range(0, 1)), 0, 0);
         total++;
         if (word_valid !== ((i == 7 || i == 15) ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL b2b_wv shift=%0d got=%b", i + 1, word_valid);
         end
      end
      total++; if (q !== 8'(m_q)) begin bad++; $display("FAIL b2b_q got=%h exp=%h", q, 8'(m_q)); end
      // en=0 mid-word freezes everything.
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 0, 0);
      held = q;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 1, 0, 0, 0);
         total++;
         if (shift_cnt !== 3'd3 || q !== held || word_valid !== 1'b0) begin
            bad++; $display("FAIL en_freeze got=%0d/%h exp=3/%h", shift_cnt, q, held);
         end
      end
      // Reset after 5 shifts discards the partial word.
      cyc(1, 1, 3, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0, 0);
      cyc(0, 1, 1, 1, 0, 0);
      total++; if (shift_cnt !== 3'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", shift_cnt); end
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 2, 0, 1, 0);
         total++;
         if (word_valid !== ((i == 7) ? 1'b1 : 1'b0)) begin
            bad++; $display("FAIL rst_mid_wv shift=%0d got=%b", i + 1, word_valid);
         end
      end
   endtask

   task automatic test_load_mid;
      logic [7:0] held;
      cyc(1, 1, 3, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, 1, 1, 1, 0, 0);
      total++; if (shift_cnt !== 3'd6) begin bad++; $display("FAIL lmid_pre got=%0d exp=6", shift_cnt); end
      cyc(1, 1, 3, 0, 0, 8'h5C);
      total++; if (shift_cnt !== 3'd0 || word_valid !== 1'b0 || q !== 8'h5C) begin
         bad++; $display("FAIL lmid got=%0d/%b/%h exp=0/0/5c", shift_cnt, word_valid, q);
      end
      cyc(1, 1, 1, 1, 0, 0);
      held = q;
      cyc(1, 1, 6, 0, 1, 8'hFF);
      cyc(1, 1, 7, 1, 0, 8'h00);
      total++; if (q !== held || shift_cnt !== 3'd1 || word_valid !== 1'b0) begin
         bad++; $display("FAIL reserved got=%h/%0d exp=%h/1", q, shift_cnt, held);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) != 0), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
         total++;
         if (q !== 8'(m_q) || shift_cnt !== 3'(m_cnt) || word_valid !== 1'(m_wv) ||
             dout !== 1'(m_q / 128) || dout_lsb !== 1'(m_q % 2)) begin
            bad++;
            $display("FAIL rand cyc=%0d got=%h/%0d/%b exp=%h/%0d/%0d", i, q, shift_cnt, word_valid, 8'(m_q), m_cnt, m_wv);
         end
      end
   endtask

   initial begin
      test_reset;
      test_siso;
      test_load_shr;
      test_rotate;
      test_edges;
      test_load_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
